// File: rtl/mips_pkg.sv
// ============================================================================
// Module   : mips_pkg
// Brief    : Shared types and widths for the MIPS core and its boot loader.
//            LOADER_CHECKSUM_EN adds the CSUM loader state.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;
    localparam int INST_W     = 32;
    localparam int BCNT_W     = $clog2(WORD_BYTES);

    typedef enum logic [2:0] {
        HDR_HI = 3'd0,
        HDR_LO = 3'd1,
        DATA   = 3'd2,
`ifdef LOADER_CHECKSUM_EN
        CSUM   = 3'd3,
`endif
        DONE   = 3'd4,
        ERR    = 3'd5
    } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/byte_assembler.sv
// ============================================================================
// Module   : byte_assembler
// Brief    : Packs a big-endian byte stream into 32-bit words; word_valid is
//            a registered one-cycle strobe following the word's last byte.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_assembler
    import mips_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              byte_en,
    input  logic [7:0]        byte_in,
    output logic [INST_W-1:0] word,
    output logic              word_valid,
    output logic              word_done
);

    localparam logic [BCNT_W-1:0] c_last_byte = BCNT_W'(WORD_BYTES - 1);

    logic [INST_W-1:0] r_shift;
    logic [BCNT_W-1:0] r_cnt;
    logic              r_word_valid;

    // High when the byte being accepted this cycle completes a word.
    assign word_done  = byte_en && (r_cnt == c_last_byte);
    assign word       = r_shift;
    assign word_valid = r_word_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_shift      <= '0;
            r_cnt        <= '0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= word_done;
            if (byte_en) begin
                r_shift <= {r_shift[INST_W-9:0], byte_in};
                r_cnt   <= r_cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/inst_loader.sv
// ============================================================================
// Module   : inst_loader
// Brief    : Boot-time byte-stream loader for the instruction memory; holds
//            the core until the program is loaded. Define LOADER_CHECKSUM_EN
//            to require a trailing XOR checksum byte.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              inst_we,
    output logic [ADDR_W-1:0] inst_addr,
    output logic [INST_W-1:0] inst_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam int CNT_W = HDR_BYTES * 8;
    localparam logic [CNT_W:0] c_max_words = (CNT_W + 1)'(1) << ADDR_W;

    loader_state_t     r_state;
    loader_state_t     w_next;
    logic [CNT_W-1:0]  r_count;
    logic [ADDR_W:0]   r_word_idx;
    logic [CNT_W-1:0]  w_hdr_n;
    logic              w_last_word;
    logic              w_byte_en;
    logic              w_word_valid;
    logic              w_word_done;
    logic [INST_W-1:0] w_word;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        r_csum;
`else
    logic              r_final;
`endif

    byte_assembler u_asm (
        .clock      (clock),
        .reset      (reset),
        .byte_en    (w_byte_en),
        .byte_in    (in_data),
        .word       (w_word),
        .word_valid (w_word_valid),
        .word_done  (w_word_done)
    );

    assign w_hdr_n     = {r_count[CNT_W-1:8], in_data};
    // Word index is one bit wider than the address so a full-memory load ends cleanly.
    assign w_last_word = ((CNT_W + 1)'(r_word_idx) + (CNT_W + 1)'(1)) == {1'b0, r_count};

    assign inst_we    = w_word_valid;
    assign inst_addr  = r_word_idx[ADDR_W-1:0];
    assign inst_wdata = w_word;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= HDR_HI;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        cpu_hold  = 1'b1;
        done      = 1'b0;
        error     = 1'b0;
        w_byte_en = 1'b0;
        case (r_state)
            HDR_HI: begin
                in_ready = 1'b1;
                if (in_valid) w_next = HDR_LO;
            end
            HDR_LO: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (w_hdr_n == '0) begin
`ifdef LOADER_CHECKSUM_EN
                        w_next = CSUM;
`else
                        w_next = DONE;
`endif
                    end else if ({1'b0, w_hdr_n} > c_max_words) begin
                        w_next = ERR;
                    end else begin
                        w_next = DATA;
                    end
                end
            end
            DATA: begin
                in_ready  = 1'b1;
                w_byte_en = in_valid;
`ifdef LOADER_CHECKSUM_EN
                if (w_word_done && w_last_word) w_next = CSUM;
`else
                // Leave one cycle after the last byte so done follows the final write strobe.
                if (r_final) w_next = DONE;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: begin
                in_ready = 1'b1;
                if (in_valid) w_next = (in_data == r_csum) ? DONE : ERR;
            end
`endif
            DONE: begin
                cpu_hold = 1'b0;
                done     = 1'b1;
            end
            ERR: begin
                error = 1'b1;
            end
            default: begin
                w_next = ERR;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count    <= '0;
            r_word_idx <= '0;
        end else begin
            if (r_state == HDR_HI && in_valid) r_count[CNT_W-1:8] <= in_data;
            if (r_state == HDR_LO && in_valid) r_count[7:0]       <= in_data;
            if (w_word_valid) r_word_idx <= r_word_idx + 1'b1;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            r_csum <= '0;
        end else if (in_valid && (r_state == HDR_HI || r_state == HDR_LO || r_state == DATA)) begin
            r_csum <= r_csum ^ in_data;
        end
    end
`else
    always_ff @(posedge clock) begin
        if (reset) begin
            r_final <= 1'b0;
        end else begin
            r_final <= (r_state == DATA) && w_word_done && w_last_word;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_inst_loader.sv
// ============================================================================
// Module   : tb_inst_loader
// Brief    : Directed self-checking bench for inst_loader; follows
//            LOADER_CHECKSUM_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_loader;

    localparam int ADDR_W = 10;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              inst_we;
    logic [ADDR_W-1:0] inst_addr;
    logic [31:0]       inst_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int                wr_n = 0;
    logic [ADDR_W-1:0] wr_addr [8];
    logic [31:0]       wr_data [8];
    int                wr_cyc  [8];
    int                done_cyc = -1;
    bit                ready_drop = 1'b0;
    logic [7:0]        stim [$];

    inst_loader #(.ADDR_W(ADDR_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .inst_we    (inst_we),
        .inst_addr  (inst_addr),
        .inst_wdata (inst_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (inst_we) begin
            if (wr_n < 8) begin
                wr_addr[wr_n] = inst_addr;
                wr_data[wr_n] = inst_wdata;
                wr_cyc[wr_n]  = cyc;
            end
            wr_n++;
        end
        if (done && done_cyc < 0) done_cyc = cyc;
        if (!reset && !in_ready && !done && !error) ready_drop = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clock);
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset      = 1'b0;
        wr_n       = 0;
        done_cyc   = -1;
        ready_drop = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the byte was taken.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = b;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL handshake: in_ready=%0b required 1 for byte %h", in_ready, b);
        end
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic send_stim(input int gap, input int count);
        for (int i = 0; i < count; i++) begin
            send_byte(stim[i]);
            repeat (gap) @(negedge clock);
        end
    endtask

    task automatic finish_stim();
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        foreach (stim[i]) x = x ^ stim[i];
        stim.push_back(x);
`endif
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (inst_we !== 1'b0) begin errors++; $display("FAIL reset_inst_we: got %b want 0", inst_we); end
        checks++; if (inst_addr !== '0) begin errors++; $display("FAIL reset_inst_addr: got %h want 0", inst_addr); end
        checks++; if (inst_wdata !== 32'h0) begin errors++; $display("FAIL reset_inst_wdata: got %h want 0", inst_wdata); end
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL reset_cpu_hold: got %b want 1", cpu_hold); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", error); end
    endtask

    task automatic test_two_words(input int gap);
        do_reset();
        stim = '{8'h00, 8'h02, 8'h01, 8'h2A, 8'h40, 8'h20, 8'h00, 8'h85, 8'h30, 8'h24};
        finish_stim();
        send_stim(gap, stim.size());
        repeat (4) @(negedge clock);
        #1;
        checks++; if (wr_n !== 2) begin errors++; $display("FAIL two_words_count gap%0d: got %0d want 2", gap, wr_n); end
        checks++; if (wr_addr[0] !== 10'd0 || wr_data[0] !== 32'h012A4020) begin
            errors++; $display("FAIL two_words_w0 gap%0d: got %h@%h want 012a4020@000", gap, wr_data[0], wr_addr[0]); end
        checks++; if (wr_addr[1] !== 10'd1 || wr_data[1] !== 32'h00853024) begin
            errors++; $display("FAIL two_words_w1 gap%0d: got %h@%h want 00853024@001", gap, wr_data[1], wr_addr[1]); end
        checks++; if (done !== 1'b1 || cpu_hold !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL two_words_end gap%0d: done=%b hold=%b ready=%b want 1 0 0", gap, done, cpu_hold, in_ready); end
        if (gap == 0) begin
            checks++; if (done_cyc !== wr_cyc[1] + 1) begin
                errors++; $display("FAIL two_words_done_timing: done cycle %0d want %0d", done_cyc, wr_cyc[1] + 1); end
            checks++; if (wr_cyc[1] - wr_cyc[0] !== 4) begin
                errors++; $display("FAIL two_words_rate: write spacing %0d want 4", wr_cyc[1] - wr_cyc[0]); end
        end else begin
            checks++; if (ready_drop !== 1'b0) begin
                errors++; $display("FAIL gaps_in_ready: in_ready dropped during load (flag %b want 0)", ready_drop); end
        end
    endtask

`ifndef LOADER_CHECKSUM_EN
    task automatic test_zero_words();
        do_reset();
        send_byte(8'h00);
        #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_early_done: got %b want 0", done); end
        send_byte(8'h00);
        #1;
        checks++; if (done !== 1'b1 || cpu_hold !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL zero_done: done=%b hold=%b ready=%b want 1 0 0", done, cpu_hold, in_ready); end
        repeat (3) @(negedge clock);
        #1;
        checks++; if (wr_n !== 0) begin errors++; $display("FAIL zero_writes: got %0d want 0", wr_n); end
    endtask
`endif

    task automatic test_overflow();
        do_reset();
        send_byte(8'h04);
        send_byte(8'h01);
        #1;
        checks++; if (error !== 1'b1 || cpu_hold !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL overflow_state: err=%b hold=%b ready=%b done=%b want 1 1 0 0", error, cpu_hold, in_ready, done); end
        repeat (3) @(negedge clock);
        #1;
        checks++; if (wr_n !== 0 || error !== 1'b1) begin
            errors++; $display("FAIL overflow_sticky: writes=%0d err=%b want 0 1", wr_n, error); end
    endtask

    task automatic test_full_boundary();
        do_reset();
        send_byte(8'h04);
        send_byte(8'h00);
        #1;
        checks++; if (error !== 1'b0 || in_ready !== 1'b1 || cpu_hold !== 1'b1) begin
            errors++; $display("FAIL full_hdr: err=%b ready=%b hold=%b want 0 1 1", error, in_ready, cpu_hold); end
        stim = '{8'h12, 8'h34, 8'h56, 8'h78};
        send_stim(0, 4);
        repeat (3) @(negedge clock);
        #1;
        checks++; if (wr_n !== 1 || wr_data[0] !== 32'h12345678 || wr_addr[0] !== 10'd0) begin
            errors++; $display("FAIL full_first_word: n=%0d got %h@%h want 1 12345678@000", wr_n, wr_data[0], wr_addr[0]); end
        checks++; if (done !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL full_not_done: done=%b ready=%b want 0 1", done, in_ready); end
    endtask

    task automatic test_reset_midload();
        do_reset();
        stim = '{8'h00, 8'h02, 8'h01, 8'h2A, 8'h40, 8'h20, 8'h00, 8'h85};
        send_stim(0, 8);
        repeat (3) @(negedge clock);
        #1;
        checks++; if (wr_n !== 1) begin errors++; $display("FAIL midload_pre_writes: got %0d want 1", wr_n); end
        do_reset();
        stim = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        finish_stim();
        send_stim(0, stim.size());
        repeat (4) @(negedge clock);
        #1;
        checks++; if (wr_n !== 1) begin errors++; $display("FAIL midload_writes: got %0d want 1", wr_n); end
        checks++; if (wr_addr[0] !== 10'd0 || wr_data[0] !== 32'hAABBCCDD) begin
            errors++; $display("FAIL midload_word: got %h@%h want aabbccdd@000", wr_data[0], wr_addr[0]); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL midload_done: got %b want 1", done); end
    endtask

`ifdef LOADER_CHECKSUM_EN
    // The checksum covers the header bytes too: 00^01^11^22^33^44 = 45.
    task automatic test_checksum();
        do_reset();
        stim = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
        send_stim(0, 7);
        repeat (2) @(negedge clock);
        #1;
        checks++; if (done !== 1'b1 || error !== 1'b0) begin
            errors++; $display("FAIL csum_good: done=%b err=%b want 1 0", done, error); end
        do_reset();
        stim = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        send_stim(0, 7);
        repeat (2) @(negedge clock);
        #1;
        checks++; if (error !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL csum_bad: err=%b hold=%b done=%b want 1 1 0", error, cpu_hold, done); end
        checks++; if (wr_n !== 1 || wr_data[0] !== 32'h11223344 || wr_addr[0] !== 10'd0) begin
            errors++; $display("FAIL csum_bad_write: n=%0d got %h@%h want 1 11223344@000", wr_n, wr_data[0], wr_addr[0]); end
    endtask
`endif

    initial begin
        test_reset();
        test_two_words(0);
        test_two_words(3);
`ifndef LOADER_CHECKSUM_EN
        test_zero_words();
`endif
        test_overflow();
        test_full_boundary();
        test_reset_midload();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
